fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, the reset: asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port push, input, 1, fetch stage offers one {PC, Instr} pair this cycle.
REQ-005 The block SHALL have port push_pc, input, 32, PC of the offered instruction.
REQ-006 The block SHALL have port push_instr, input, 32, offered instruction word.
REQ-007 The block SHALL have port full, output, 1, high when count == DEPTH.
REQ-008 The block SHALL have port pop, input, 1, decode stage consumes the head entry this cycle.
REQ-009 The block SHALL have port valid, output, 1, head entry present on pc_out/instr_out.
REQ-010 The block SHALL have port pc_out, output, 32, PC of the head entry.
REQ-011 The block SHALL have port instr_out, output, 32, instruction word of the head entry.
REQ-012 The block SHALL have port flush, input, 1, discard all entries (branch/jump redirect).
REQ-013 The block SHALL have port count, output, 4, current occupancy, 0..DEPTH.

Function
REQ-014 The block SHALL store entries in a circular buffer with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 On push with !full, the block SHALL write {push_pc, push_instr} at the write pointer and advance it at the clock edge.
REQ-016 On push while full and no pop, the block SHALL drop the push; state SHALL be unchanged.
REQ-017 On push while full with pop in the same cycle, the block SHALL accept both; count SHALL stay DEPTH.
REQ-018 On pop with valid, the block SHALL advance the read pointer at the clock edge; pop with !valid SHALL be ignored.
REQ-019 Simultaneous accepted push and pop SHALL leave count unchanged.
REQ-020 Flush SHALL take priority over push and pop: at the edge, both pointers and count SHALL return to 0, and any same-cycle push SHALL be dropped.
REQ-021 valid, pc_out and instr_out SHALL be driven combinationally from the head entry; minimum push-to-valid latency is one cycle (without bypass).
REQ-022 When valid is low, pc_out and instr_out SHALL be 32'h0000_0000 (nop).
REQ-023 count SHALL equal the number of stored entries, and full SHALL equal (count == DEPTH), both registered-derived with no dependency on same-cycle push/pop.

Reset
REQ-024 While reset is low, the block SHALL hold pointers and count at 0, with valid=0, full=0, pc_out=0 and instr_out=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately; storage contents need not be cleared.
REQ-026 After reset deasserts, the first rising edge SHALL accept a push normally.

Configuration
REQ-027 With FETCH_QUEUE_BYPASS_EN defined, when count == 0, push=1, pop=1 and flush=0, the block SHALL drive valid=1, pc_out=push_pc and instr_out=push_instr combinationally, and SHALL NOT store the entry (count stays 0).
REQ-028 With FETCH_QUEUE_BYPASS_EN defined, when count == 0 and push=1 but pop=0, the block SHALL still drive the bypass outputs and SHALL store the entry.
REQ-029 Without FETCH_QUEUE_BYPASS_EN, outputs SHALL depend only on stored state; REQ-021 latency applies.

Verification
REQ-030 Reset low, then push 0x3000/0x2408_0001, 0x3004/0x2409_0002, then pop twice -> outputs in order; count goes 1,2,1,0; valid=0 after.
REQ-031 Push 4 entries (DEPTH=4) -> full=1; push 0x3010 alone -> dropped, count=4; push 0x3010 with pop -> head 0x3000 leaves, tail 0x3010, count=4.
REQ-032 Push/pop 10 entries continuously at PC 0x3000+4n -> pointers wrap, pc_out sequence is exact, no loss or duplication.
REQ-033 With 3 entries stored, assert flush with push=1 -> next cycle count=0, valid=0, pc_out=0; pushed entry is absent.
REQ-034 Reset low asynchronously between edges with count=2 -> valid=0 and count=0 before the next clk edge.
REQ-035 With FETCH_QUEUE_BYPASS_EN, empty queue, push+pop 0x3020/0x0800_0C00 -> same-cycle valid=1, instr_out=0x0800_0C00, count stays 0; without the macro, valid=0 that cycle and 1 the next.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction-fetch buffer between fetch and decode.
// Each entry holds a {PC, instruction} pair. Flush has priority over push and pop.
// The head entry is presented combinationally, and pc_out/instr_out read 0 (nop) when empty.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to add an empty-queue bypass.
// With the bypass, a push into an empty queue appears on the outputs in the same cycle.
// If decode pops in that same cycle, the entry is consumed without being stored.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    output logic        full,
    input  logic        pop,
    output logic        valid,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    input  logic        flush,
    output logic [3:0]  count
);

    // DEPTH is restricted to powers of two, so the pointers wrap by plain overflow.
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
    localparam logic [3:0]     DEPTH_CNT = 4'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;

    logic stored_valid;
    logic pop_ok;
    logic push_ok;
    logic bypass_take;

    assign stored_valid = (count_q != 4'd0);
    assign full         = (count_q == DEPTH_CNT);
    assign count        = count_q;

    // Decide which of this cycle's requests are actually accepted at the edge
    always_comb begin
        bypass_take = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_take = !stored_valid && push && pop && !flush;
`endif
        pop_ok  = pop && stored_valid && !flush;
        // A full queue can still take a push when the head leaves in the same cycle
        push_ok = push && !flush && !bypass_take && (!full || pop_ok);
    end

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 4'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 4'd1;
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - 4'd1;
            end
        end
    end

    // Pointer and count registers; reset empties the queue immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_pc, push_instr};
        end
    end

    // Head presentation: stored head first, otherwise optional bypass, otherwise nop
    always_comb begin
        valid     = stored_valid;
        pc_out    = 32'h0000_0000;
        instr_out = 32'h0000_0000;
        if (stored_valid) begin
            {pc_out, instr_out} = mem_q[rd_ptr_q];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (reset && push && !flush) begin
            valid     = 1'b1;
            pc_out    = push_pc;
            instr_out = push_instr;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus against a queue-based reference model.
// The model is compared every cycle, and literal expectations pin key points.
// Build with FETCH_QUEUE_BYPASS_EN defined to exercise the bypass variant.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        push;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic        full;
    logic        pop;
    logic        valid;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        flush;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    logic [63:0] model_q [$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_pc   (push_pc),
        .push_instr(push_instr),
        .full      (full),
        .pop       (pop),
        .valid     (valid),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated by the queue rules at each edge
    always @(posedge clk or negedge reset) begin
        int  n;
        bit  pop_acc;
        bit  push_acc;
        bit  bypass_hit;
        if (!reset) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            n          = model_q.size();
            bypass_hit = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            bypass_hit = (n == 0) && push && pop;
`endif
            if (!bypass_hit) begin
                pop_acc  = pop && (n > 0);
                push_acc = push && ((n < DEPTH) || pop_acc);
                if (pop_acc)  void'(model_q.pop_front());
                if (push_acc) model_q.push_back({push_pc, push_instr});
            end
        end
    end

    // Per-cycle compare of all outputs against the model, mid-cycle
    always @(negedge clk) begin
        logic        ev;
        logic [63:0] eo;
        ev = (model_q.size() > 0);
        eo = ev ? model_q[0] : 64'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (!ev && push && !flush && reset) begin
            ev = 1'b1;
            eo = {push_pc, push_instr};
        end
`endif
        chk("model_valid", 32'(valid), 32'(ev));
        chk("model_pc",    pc_out,     eo[63:32]);
        chk("model_instr", instr_out,  eo[31:0]);
        chk("model_count", 32'(count), 32'(model_q.size()));
        chk("model_full",  32'(full),  32'(model_q.size() == DEPTH));
        $display("cyc t=%0t push=%0b pop=%0b flush=%0b count=%0d valid=%0b pc=%h instr=%h",
                 $time, push, pop, flush, count, valid, pc_out, instr_out);
    end

    task automatic drive(input logic p, input logic [31:0] pc, input logic [31:0] ins,
                         input logic po, input logic fl);
        push       = p;
        push_pc    = pc;
        push_instr = ins;
        pop        = po;
        flush      = fl;
    endtask

    // Advance one edge, then return inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic step(input logic p, input logic [31:0] pc, input logic [31:0] ins,
                        input logic po, input logic fl);
        drive(p, pc, ins, po, fl);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_pc",    pc_out,     32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Two pushes then two pops, first edge after reset accepts
        step(1'b1, 32'h3000, 32'h2408_0001, 1'b0, 1'b0);
        chk("seq_count1", 32'(count), 32'd1);
        chk("seq_head1",  pc_out,     32'h3000);
        step(1'b1, 32'h3004, 32'h2409_0002, 1'b0, 1'b0);
        chk("seq_count2", 32'(count), 32'd2);
        chk("seq_instr2", instr_out,  32'h2408_0001);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("seq_count3", 32'(count), 32'd1);
        chk("seq_head3",  pc_out,     32'h3004);
        chk("seq_instr3", instr_out,  32'h2409_0002);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("seq_count4", 32'(count), 32'd0);
        chk("seq_valid4", 32'(valid), 32'd0);
        chk("seq_pc4",    pc_out,     32'h0);

        // Pop on empty is ignored
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("empty_pop_count", 32'(count), 32'd0);

        // Fill to full, dropped push, then push with pop while full
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd4);
        step(1'b1, 32'h3010, 32'h1000_0010, 1'b0, 1'b0);
        chk("drop_count", 32'(count), 32'd4);
        chk("drop_head",  pc_out,     32'h3000);
        step(1'b1, 32'h3010, 32'h1000_0010, 1'b1, 1'b0);
        chk("pp_full_count", 32'(count), 32'd4);
        chk("pp_full_head",  pc_out,     32'h3004);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("tail_head",  pc_out,     32'h3010);
        chk("tail_instr", instr_out,  32'h1000_0010);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("tail_empty", 32'(count), 32'd0);

        // Continuous push/pop of 10 entries: pointers wrap repeatedly
        step(1'b1, 32'h3000, 32'hA000_0000, 1'b0, 1'b0);
        for (int n = 1; n < 10; n++) begin
            step(1'b1, 32'h3000 + 32'(4 * n), 32'hA000_0000 + 32'(n), 1'b1, 1'b0);
            chk("stream_head", pc_out, 32'h3000 + 32'(4 * n));
            chk("stream_count", 32'(count), 32'd1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_end", 32'(count), 32'd0);

        // Flush with three stored entries and a same-cycle push
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3100 + 32'(4 * i), 32'hB000_0000, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd3);
        step(1'b1, 32'h3200, 32'hC000_0000, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(valid), 32'd0);
        chk("flush_pc",    pc_out,     32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_absent", 32'(count), 32'd0);

        // Asynchronous reset between edges with two entries stored
        step(1'b1, 32'h3040, 32'hD000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h3044, 32'hD000_0001, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_pc",    pc_out,     32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 32'h3048, 32'hD000_0002, 1'b0, 1'b0);
        chk("post_rst_head", pc_out, 32'h3048);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Push+pop into an empty queue
        drive(1'b1, 32'h3020, 32'h0800_0C00, 1'b1, 1'b0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(valid), 32'd1);
        chk("byp_instr", instr_out,  32'h0800_0C00);
        tick();
        chk("byp_count", 32'(count), 32'd0);
`else
        chk("nobyp_valid", 32'(valid), 32'd0);
        tick();
        chk("nobyp_valid_next", 32'(valid), 32'd1);
        chk("nobyp_instr_next", instr_out,  32'h0800_0C00);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
